// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: bus width, word type and outport status-word bit positions.
`default_nettype none

package cpu_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam int OPS_VALID   = 0;
  localparam int OPS_OVF     = 1;
  localparam int OPS_FULL    = 2;
  localparam int OPS_CNT_LSB = 3;

endpackage

`default_nettype wire

// File: rtl/outport_fifo.sv
// outport_fifo: circular buffer with pointers, count, push/pop arbitration and next-head lookahead.
`default_nettype none

module outport_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push_req,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  count_next,
  output logic              head_load,
  output logic [WORD_W-1:0] head_next
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok  = pop && (count != '0);
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = push_req && ((count != FULL_CNT) || pop_ok);
  assign rd_next = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // The head changes only when the old head leaves or the first word arrives;
  // an emptying FIFO keeps the last word on the port.
  assign head_load = (count_next != '0) && (pop_ok || (count == '0));
  // New head may be the word being written on this very edge.
  assign head_next = (push_ok && (wr_ptr == rd_next)) ? wdata : mem[rd_next];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_next;
      count  <= count_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/outport_unit.sv
// outport_unit: CPU output port buffering bus words into a FIFO behind a valid/ready handshake.
// Optional status readback onto bus_out when OUTPORT_STATUS_EN is defined.
`default_nettype none

module outport_unit #(
  parameter int WORD_W = cpu_pkg::WORD_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WORD_W-1:0] bus_in,
  input  logic              outportin,
  output logic [WORD_W-1:0] outport_data,
  output logic              outport_valid,
  input  logic              outport_ready,
  output logic              outport_full,
  output logic              outport_ovf,
  input  logic              ovf_clr
`ifdef OUTPORT_STATUS_EN
  ,
  input  logic              statusout,
  output logic [WORD_W-1:0] bus_out
`endif
);

  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              head_load;
  logic [WORD_W-1:0] head_next;
  logic              pop;
  logic              drop;

  assign pop  = outport_valid && outport_ready;
  assign drop = outportin && (count == FULL_CNT) && !pop;

  outport_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .clr        (clr),
    .push_req   (outportin),
    .wdata      (bus_in),
    .pop        (pop),
    .count      (count),
    .count_next (count_next),
    .head_load  (head_load),
    .head_next  (head_next)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      outport_data  <= '0;
      outport_valid <= 1'b0;
      outport_full  <= 1'b0;
      outport_ovf   <= 1'b0;
    end else begin
      outport_valid <= (count_next != '0);
      outport_full  <= (count_next == FULL_CNT);
      if (head_load) begin
        outport_data <= head_next;
      end
      // A new drop beats a simultaneous clear.
      if (drop) begin
        outport_ovf <= 1'b1;
      end else if (ovf_clr) begin
        outport_ovf <= 1'b0;
      end
    end
  end

`ifdef OUTPORT_STATUS_EN
  always_comb begin
    bus_out = '0;
    if (statusout) begin
      bus_out[OPS_VALID]                = outport_valid;
      bus_out[OPS_OVF]                  = outport_ovf;
      bus_out[OPS_FULL]                 = outport_full;
      bus_out[OPS_CNT_LSB +: CNT_W]     = count;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_outport_unit.sv
// tb_outport_unit: scoreboard bench for outport_unit (status tests only with OUTPORT_STATUS_EN).
`default_nettype none

module tb_outport_unit;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic [W-1:0] bus_in;
  logic         outportin;
  logic [W-1:0] outport_data;
  logic         outport_valid;
  logic         outport_ready;
  logic         outport_full;
  logic         outport_ovf;
  logic         ovf_clr;
`ifdef OUTPORT_STATUS_EN
  logic         statusout;
  logic [W-1:0] bus_out;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] last_data;
  logic         exp_ovf;

  always #5 clk = ~clk;

  outport_unit #(.WORD_W(W), .DEPTH(D)) dut (
    .clk           (clk),
    .clr           (clr),
    .bus_in        (bus_in),
    .outportin     (outportin),
    .outport_data  (outport_data),
    .outport_valid (outport_valid),
    .outport_ready (outport_ready),
    .outport_full  (outport_full),
    .outport_ovf   (outport_ovf),
    .ovf_clr       (ovf_clr)
`ifdef OUTPORT_STATUS_EN
    ,
    .statusout     (statusout),
    .bus_out       (bus_out)
`endif
  );

  // One clock of stimulus; the scoreboard front is compared against the port every cycle
  // and retired when the handshake fires.
  task automatic step(input logic push, input logic [W-1:0] wd, input logic rdy, input logic oclr);
    int  cnt;
    logic pop;
    @(negedge clk);
    outportin = push; bus_in = wd; outport_ready = rdy; ovf_clr = oclr;
    cnt = q.size();
    tests++;
    if (outport_valid !== (cnt != 0)) begin
      fails++; $display("FAIL valid: got %b exp %b", outport_valid, (cnt != 0));
    end
    tests++;
    if (outport_full !== (cnt == D)) begin
      fails++; $display("FAIL full: got %b exp %b", outport_full, (cnt == D));
    end
    tests++;
    if (outport_ovf !== exp_ovf) begin
      fails++; $display("FAIL ovf: got %b exp %b", outport_ovf, exp_ovf);
    end
    tests++;
    if (cnt != 0) begin
      if (outport_data !== q[0]) begin
        fails++; $display("FAIL head_data: got %h exp %h", outport_data, q[0]);
      end
    end else if (outport_data !== last_data) begin
      fails++; $display("FAIL held_data: got %h exp %h", outport_data, last_data);
    end
    pop = rdy && (cnt != 0);
    if (pop) last_data = q.pop_front();
    if (push) begin
      if (cnt < D || pop) q.push_back(wd);
      else exp_ovf = 1'b1;
    end
    if (!(push && cnt == D && !pop) && oclr) exp_ovf = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr = 1'b0; outportin = 1'b1; bus_in = 32'hDEAD_BEEF; outport_ready = 1'b1; ovf_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q.delete(); last_data = '0; exp_ovf = 1'b0;
    tests++;
    if (outport_valid !== 1'b0 || outport_full !== 1'b0 || outport_ovf !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got v=%b f=%b o=%b exp 0/0/0", outport_valid, outport_full, outport_ovf);
    end
    tests++;
    if (outport_data !== '0) begin
      fails++; $display("FAIL reset_data: got %h exp 0", outport_data);
    end
    clr = 1'b1; outportin = 1'b0; outport_ready = 1'b0;
  endtask

  task automatic test_single();
    step(1'b1, 32'h0000_00AB, 1'b0, 1'b0);
    #1;
    tests++;
    if (outport_valid !== 1'b1 || outport_data !== 32'hAB) begin
      fails++; $display("FAIL single_latency: got v=%b d=%h exp 1 000000ab", outport_valid, outport_data);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    #1;
    tests++;
    if (outport_valid !== 1'b0 || outport_data !== 32'hAB) begin
      fails++; $display("FAIL single_hold: got v=%b d=%h exp 0 000000ab", outport_valid, outport_data);
    end
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    #1;
    tests++;
    if (outport_full !== 1'b1 || outport_data !== 32'h1) begin
      fails++; $display("FAIL fill: got f=%b d=%h exp 1 00000001", outport_full, outport_data);
    end
    step(1'b1, 32'h5, 1'b0, 1'b0);
    #1;
    tests++;
    if (outport_ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_set: got %b exp 1", outport_ovf);
    end
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    #1;
    tests++;
    if (outport_ovf !== 1'b0 || outport_data !== 32'h4) begin
      fails++; $display("FAIL ovf_clr: got o=%b d=%h exp 0 00000004", outport_ovf, outport_data);
    end
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    step(1'b1, 32'h9, 1'b1, 1'b0);
    #1;
    tests++;
    if (outport_full !== 1'b1 || outport_ovf !== 1'b0 || outport_data !== 32'h2) begin
      fails++; $display("FAIL full_push_pop: got f=%b o=%b d=%h exp 1 0 00000002", outport_full, outport_ovf, outport_data);
    end
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) step(1'b1, 32'h10 + W'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    #1;
    tests++;
    if (outport_valid !== 1'b0 || outport_data !== 32'h19) begin
      fails++; $display("FAIL wrap_end: got v=%b d=%h exp 0 00000019", outport_valid, outport_data);
    end
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + W'(i), 1'b0, 1'b0);
    test_reset();
    step(1'b1, 32'h7, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #1;
    tests++;
    if (outport_data !== 32'h7 || outport_valid !== 1'b0) begin
      fails++; $display("FAIL post_reset: got v=%b d=%h exp 0 00000007", outport_valid, outport_data);
    end
  endtask

`ifdef OUTPORT_STATUS_EN
  task automatic test_status();
    for (int i = 1; i <= 5; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    outport_ready = 1'b0; outportin = 1'b0; statusout = 1'b1;
    #1;
    tests++;
    if (bus_out !== 32'h0000_0013) begin
      fails++; $display("FAIL status_on: got %h exp 00000013", bus_out);
    end
    statusout = 1'b0;
    #1;
    tests++;
    if (bus_out !== '0) begin
      fails++; $display("FAIL status_off: got %h exp 0", bus_out);
    end
  endtask
`endif

  initial begin
    clr = 1'b0; outportin = 1'b0; bus_in = '0; outport_ready = 1'b0; ovf_clr = 1'b0;
`ifdef OUTPORT_STATUS_EN
    statusout = 1'b0;
`endif
    last_data = '0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_mid_reset();
`ifdef OUTPORT_STATUS_EN
    test_reset();
    test_status();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
